// File: rtl/sha256_core_ctrl.sv
// SHA-256 core sequencer: loads 16-word blocks into ME, steps ME/MC through
// init/load/compress/output over FSM_core/core_count, and streams the digest.
module sha256_core_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic                  msg_valid_in,
  input  logic [DATA_WIDTH-1:0] msg_data_in,
  input  logic                  msg_last_in,
  output logic                  msg_ready_out,
  output logic                  msg_we_out,
  output logic [DATA_WIDTH-1:0] msg_word_out,
  input  logic [DATA_WIDTH-1:0] mc_data_in,
  output logic [2:0]            FSM_core_out,
  output logic [6:0]            core_count_out,
  output logic                  digest_valid_out,
  output logic [DATA_WIDTH-1:0] digest_data_out,
  output logic                  done_out,
  output logic                  busy_out
);

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_INIT     = 3'b010;
  localparam logic [2:0] S_LOAD     = 3'b001;
  localparam logic [2:0] S_COMPRESS = 3'b011;
  localparam logic [2:0] S_OUTPUT   = 3'b100;

  logic [2:0]            state_q, state_d;
  logic [6:0]            count_q, count_d;
  logic                  last_q, last_d;
  logic                  dvalid_q, dvalid_d;
  logic [DATA_WIDTH-1:0] ddata_q, ddata_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    last_d   = last_q;
    dvalid_d = 1'b0;
    ddata_d  = ddata_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_INIT;
          count_d = '0;
          last_d  = 1'b0;
        end
      end
      S_INIT: begin
        state_d = S_LOAD;
        count_d = '0;
      end
      S_LOAD: begin
        if (msg_valid_in) begin
          if (count_q == 7'd15) begin
            last_d  = msg_last_in;
            state_d = S_COMPRESS;
            count_d = '0;
          end else begin
            count_d = count_q + 7'd1;
          end
        end
      end
      S_COMPRESS: begin
        if (count_q == 7'd63) begin
          count_d = '0;
          // Non-final blocks go straight back to LOAD so MC chains the hash.
          state_d = last_q ? S_OUTPUT : S_LOAD;
        end else begin
          count_d = count_q + 7'd1;
        end
      end
      S_OUTPUT: begin
        ddata_d  = mc_data_in;
        dvalid_d = 1'b1;
        if (count_q == 7'd7) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 7'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        last_d  = 1'b0;
      end
    endcase

    if (abort_in) begin
      state_d  = S_IDLE;
      count_d  = '0;
      last_d   = 1'b0;
      dvalid_d = 1'b0;
      done_d   = 1'b0;
      ddata_d  = ddata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      last_q   <= 1'b0;
      dvalid_q <= 1'b0;
      ddata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      last_q   <= last_d;
      dvalid_q <= dvalid_d;
      ddata_q  <= ddata_d;
      done_q   <= done_d;
    end
  end

  assign msg_ready_out    = (state_q == S_LOAD);
  assign msg_we_out       = msg_valid_in & msg_ready_out;
  assign msg_word_out     = msg_data_in;
  assign FSM_core_out     = state_q;
  assign core_count_out   = count_q;
  assign digest_valid_out = dvalid_q;
  assign digest_data_out  = ddata_q;
  assign done_out         = done_q;
  assign busy_out         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_core_ctrl.sv
// Directed bench for sha256_core_ctrl: ME write capture and an MC digest
// stub around the sequencer, with cycle-exact timing checks.
module tb_sha256_core_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_in, abort_in, msg_valid_in, msg_last_in;
  logic [31:0] msg_data_in, mc_data_in, msg_word_out, digest_data_out;
  logic        msg_ready_out, msg_we_out, digest_valid_out, done_out, busy_out;
  logic [2:0]  fsm;
  logic [6:0]  cnt;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int T;
  int init_cnt = 0, me_wr_cnt = 0, bad_we = 0;
  int base_init, base_wr, base_bad;

  logic [31:0] me_mem [16];
  logic [31:0] blk [16];
  logic [31:0] cur_dig [8];
  logic [31:0] abc_dig [8];
  logic [31:0] two_dig [8];

  sha256_core_ctrl #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_in         (start_in),
    .abort_in         (abort_in),
    .msg_valid_in     (msg_valid_in),
    .msg_data_in      (msg_data_in),
    .msg_last_in      (msg_last_in),
    .msg_ready_out    (msg_ready_out),
    .msg_we_out       (msg_we_out),
    .msg_word_out     (msg_word_out),
    .mc_data_in       (mc_data_in),
    .FSM_core_out     (fsm),
    .core_count_out   (cnt),
    .digest_valid_out (digest_valid_out),
    .digest_data_out  (digest_data_out),
    .done_out         (done_out),
    .busy_out         (busy_out)
  );

  // MC stub: presents the expected digest word for the current index in OUTPUT.
  assign mc_data_in = (fsm == 3'b100) ? cur_dig[cnt[2:0]] : 32'h0BAD_F00D;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (msg_we_out) begin
      me_mem[cnt[3:0]] <= msg_word_out;
      me_wr_cnt <= me_wr_cnt + 1;
      if (fsm != 3'b001) bad_we <= bad_we + 1;
    end
    if (fsm == 3'b010) init_cnt <= init_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_abc();
    for (int k = 0; k < 16; k++) blk[k] = 32'h0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    for (int k = 0; k < 8; k++) cur_dig[k] = abc_dig[k];
  endtask

  task automatic set_two(input int b);
    logic [31:0] w;
    for (int k = 0; k < 16; k++) blk[k] = 32'h0;
    if (b == 1) begin
      w = 32'h6162_6364;
      for (int k = 0; k < 14; k++) begin
        blk[k] = w;
        w = w + 32'h0101_0101;
      end
      blk[14] = 32'h8000_0000;
    end else begin
      blk[15] = 32'h0000_01C0;
    end
  endtask

  task automatic snap();
    base_init = init_cnt;
    base_wr   = me_wr_cnt;
    base_bad  = bad_we;
  endtask

  task automatic chk_me(input string tag);
    for (int k = 0; k < 16; k++) chk(tag, me_mem[k], blk[k]);
  endtask

  // Called at a negedge; T is the cycle in which start_in is presented.
  task automatic start_msg();
    @(negedge clk);
    start_in = 1'b1;
    T = cyc;
    @(negedge clk);
    start_in = 1'b0;
    chk("init_state", {29'b0, fsm}, 32'h2);
    chk("init_busy", {31'b0, busy_out}, 32'h1);
    chk("init_ready", {31'b0, msg_ready_out}, 32'h0);
  endtask

  task automatic send_block(input logic lastb, input int gap_at, input int gap_len, input bit spur);
    int i = 0;
    int gl = gap_len;
    int g = 0;
    logic hs;
    while (i < 16 && g < 300) begin
      if (i == gap_at && gl > 0) begin
        msg_valid_in = 1'b0;
        chk("gap_count_hold", {25'b0, cnt}, 32'(gap_at));
        gl--;
      end else begin
        msg_valid_in = 1'b1;
        msg_data_in  = blk[i];
        msg_last_in  = (i == 15) ? lastb : 1'b0;
      end
      start_in = spur && (i == 3);
      hs = msg_valid_in && msg_ready_out;
      @(negedge clk);
      if (spur && i == 3 && hs) chk("start_ignored_load", {29'b0, fsm}, 32'h1);
      if (hs) i++;
      g++;
    end
    msg_valid_in = 1'b0;
    msg_last_in  = 1'b0;
    start_in     = 1'b0;
    chk("block_sent", 32'(i), 32'd16);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int g = 0;
    while (fsm != s && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk(tag, {29'b0, fsm}, {29'b0, s});
  endtask

  task automatic collect(input int exp_done, input bit spur);
    int n = 0;
    int g = 0;
    while (n < 8 && g < 400) begin
      if (digest_valid_out) begin
        chk("digest_word", digest_data_out, cur_dig[n]);
        chk("done_flag", {31'b0, done_out}, (n == 7) ? 32'h1 : 32'h0);
        if (n == 7) chk("done_cycle", 32'(cyc), 32'(exp_done));
        n++;
      end
      start_in = spur && (fsm == 3'b100) && (cnt == 7'd2);
      @(negedge clk);
      g++;
    end
    start_in = 1'b0;
    chk("digest_count", 32'(n), 32'd8);
    chk("idle_after", {29'b0, fsm}, 32'h0);
    chk("busy_after", {31'b0, busy_out}, 32'h0);
    chk("valid_drop", {31'b0, digest_valid_out}, 32'h0);
    chk("done_drop", {31'b0, done_out}, 32'h0);
  endtask

  task automatic abc_run(input int gap_at, input int gap_len, input bit spur);
    int g = 0;
    set_abc();
    snap();
    start_msg();
    send_block(1'b1, gap_at, gap_len, spur);
    if (spur) begin
      while (fsm == 3'b011 && g < 100) begin
        msg_valid_in = 1'b1;
        msg_data_in  = 32'hBAD0_BAD0;
        start_in     = (cnt == 7'd10);
        if (cnt == 7'd10) chk("we_in_compress", {31'b0, msg_we_out}, 32'h0);
        if (cnt == 7'd11) chk("start_ignored_compress", {29'b0, fsm}, 32'h3);
        @(negedge clk);
        g++;
      end
      msg_valid_in = 1'b0;
      start_in     = 1'b0;
    end
    collect(T + 90 + gap_len, spur);
    chk_me("me_word_abc");
    chk("me_writes", 32'(me_wr_cnt - base_wr), 32'd16);
    chk("stray_we", 32'(bad_we - base_bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    abc_dig = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    two_dig = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    rst_n = 1'b0; start_in = 1'b0; abort_in = 1'b0;
    msg_valid_in = 1'b0; msg_last_in = 1'b0; msg_data_in = 32'h0;
    for (int k = 0; k < 8; k++) cur_dig[k] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_state", {29'b0, fsm}, 32'h0);
    chk("rst_count", {25'b0, cnt}, 32'h0);
    chk("rst_ready", {31'b0, msg_ready_out}, 32'h0);
    chk("rst_we", {31'b0, msg_we_out}, 32'h0);
    chk("rst_dvalid", {31'b0, digest_valid_out}, 32'h0);
    chk("rst_ddata", digest_data_out, 32'h0);
    chk("rst_done", {31'b0, done_out}, 32'h0);
    chk("rst_busy", {31'b0, busy_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {29'b0, fsm}, 32'h0);

    // Single block "abc".
    abc_run(-1, 0, 1'b0);

    // Two-block message, INIT only once.
    set_two(1);
    for (int k = 0; k < 8; k++) cur_dig[k] = two_dig[k];
    snap();
    start_msg();
    send_block(1'b0, -1, 0, 1'b0);
    wait_state("reload_state", 3'b001);
    chk("reload_cycle", 32'(cyc), 32'(T + 82));
    chk_me("me_word_blk1");
    set_two(2);
    send_block(1'b1, -1, 0, 1'b0);
    collect(T + 170, 1'b0);
    chk_me("me_word_blk2");
    chk("init_once", 32'(init_cnt - base_init), 32'd1);
    chk("me_writes_two", 32'(me_wr_cnt - base_wr), 32'd32);

    // LOAD gap of 3 cycles after word 5.
    abc_run(6, 3, 1'b0);

    // Abort at COMPRESS round 30.
    begin
      int g = 0;
      int seen = 0;
      set_abc();
      start_msg();
      send_block(1'b1, -1, 0, 1'b0);
      while (!(fsm == 3'b011 && cnt == 7'd30) && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("abort_reach_r30", {25'b0, cnt}, 32'd30);
      abort_in = 1'b1;
      @(negedge clk);
      abort_in = 1'b0;
      chk("abort_state", {29'b0, fsm}, 32'h0);
      chk("abort_busy", {31'b0, busy_out}, 32'h0);
      chk("abort_count", {25'b0, cnt}, 32'h0);
      chk("abort_dvalid", {31'b0, digest_valid_out}, 32'h0);
      chk("abort_done", {31'b0, done_out}, 32'h0);
      chk("abort_ddata_held", digest_data_out, 32'hf20015ad);
      for (int k = 0; k < 100; k++) begin
        if (digest_valid_out || busy_out) seen++;
        @(negedge clk);
      end
      chk("abort_quiet", 32'(seen), 32'd0);
    end
    abc_run(-1, 0, 1'b0);

    // Spurious start_in and msg_valid_in outside their states.
    abc_run(-1, 0, 1'b1);

    // Reset during OUTPUT word 3.
    begin
      int g = 0;
      set_abc();
      start_msg();
      send_block(1'b1, -1, 0, 1'b0);
      while (!(fsm == 3'b100 && cnt == 7'd3) && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("rstmid_reach", {25'b0, cnt}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_state", {29'b0, fsm}, 32'h0);
      chk("rstmid_count", {25'b0, cnt}, 32'h0);
      chk("rstmid_ready", {31'b0, msg_ready_out}, 32'h0);
      chk("rstmid_we", {31'b0, msg_we_out}, 32'h0);
      chk("rstmid_dvalid", {31'b0, digest_valid_out}, 32'h0);
      chk("rstmid_ddata", digest_data_out, 32'h0);
      chk("rstmid_done", {31'b0, done_out}, 32'h0);
      chk("rstmid_busy", {31'b0, busy_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_idle", {29'b0, fsm}, 32'h0);
    end
    abc_run(-1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
